// File: rtl/apb_master.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS bus
// transfers and returns one response per command (read data or timeout).
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  // Every output is a flop; the whole register set lives in one struct so the
  // next-state process can compute it in one place.
  typedef struct packed {
    state_t                st;
    logic [CW-1:0]         wcnt;
    logic                  cmd_ready;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
  } regs_t;

  regs_t r, n;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r <= '0;
    else          r <= n;
  end

  always_comb begin
    n           = r;
    n.rsp_valid = 1'b0;
    case (r.st)
      IDLE: begin
        // Also the path that raises cmd_ready on the first edge after reset.
        n.cmd_ready = 1'b1;
        if (cmd_valid && r.cmd_ready) begin
          n.st        = SETUP;
          n.cmd_ready = 1'b0;
          n.psel      = 1'b1;
          n.penable   = 1'b0;
          n.pwrite    = cmd_write;
          n.paddr     = cmd_addr;
          n.pwdata    = cmd_wdata;
        end
      end
      SETUP: begin
        n.st      = ACCESS;
        n.penable = 1'b1;
        n.wcnt    = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          n.st        = IDLE;
          n.psel      = 1'b0;
          n.penable   = 1'b0;
          n.cmd_ready = 1'b1;
          n.rsp_valid = 1'b1;
          n.rsp_err   = 1'b0;
          n.rsp_rdata = r.pwrite ? '0 : PRDATA;
        end else if (r.wcnt == CW'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive low-PREADY edge: abort with an error.
          n.st        = IDLE;
          n.psel      = 1'b0;
          n.penable   = 1'b0;
          n.cmd_ready = 1'b1;
          n.rsp_valid = 1'b1;
          n.rsp_err   = 1'b1;
          n.rsp_rdata = '0;
        end else begin
          n.wcnt = r.wcnt + CW'(1);
        end
      end
      default: n.st = IDLE;
    endcase
  end

  assign cmd_ready = r.cmd_ready;
  assign rsp_valid = r.rsp_valid;
  assign rsp_rdata = r.rsp_rdata;
  assign rsp_err   = r.rsp_err;
  assign PADDR     = r.paddr;
  assign PSELx     = r.psel;
  assign PENABLE   = r.penable;
  assign PWRITE    = r.pwrite;
  assign PWDATA    = r.pwdata;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, randomized transfers against a
// transaction-level model, plus reset and back-to-back sequences.
module tb_apb_master;
  localparam int TIMEOUT = 16;

  logic        PCLK, PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSELx, PENABLE, PWRITE, PREADY;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;   // ACCESS edges with PREADY low before it rises
    logic [31:0] prd;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_pen; // cycles with PENABLE high
  } vec_t;

  // Transaction-level expectation: the slave either answers within the
  // allowed number of wait edges or the transfer is cut off at TIMEOUT.
  function automatic vec_t ref_model(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int waits,
                                     input logic [31:0] prd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.prd = prd;
    v.exp_err = (waits >= TIMEOUT);
    v.exp_rd  = (wr || v.exp_err) ? 32'h0 : prd;
    v.exp_pen = v.exp_err ? TIMEOUT : waits + 1;
    return v;
  endfunction

  // Starts and finishes on a falling edge.
  task automatic run_xfer(input vec_t v, input string tag);
    int g, pen_cyc, lowc;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PREADY = 1'b0;
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge PCLK); g++; end
    if (g >= 20) chk({tag, "_ready_bound"}, 64'(g), 64'(0));
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~v.wr;
    chk({tag, "_setup_ctl"}, {61'h0, PSELx, PENABLE, cmd_ready}, 64'b100);
    chk({tag, "_setup_bus"}, {PADDR, PWDATA}, {v.addr, v.wdata});
    chk({tag, "_setup_dir"}, 64'(PWRITE), 64'(v.wr));
    PREADY = 1'($urandom); PRDATA = $urandom;
    @(negedge PCLK);
    pen_cyc = 0; lowc = 0; g = 0;
    while (PSELx && PENABLE && g < 64) begin
      pen_cyc++; g++;
      chk({tag, "_access_bus"}, {PADDR, PWDATA, 31'h0, PWRITE, cmd_ready},
          {v.addr, v.wdata, 31'h0, v.wr, 1'b0});
      PREADY = (lowc >= v.waits);
      PRDATA = PREADY ? v.prd : $urandom;
      if (!PREADY) lowc++;
      @(negedge PCLK);
    end
    if (g >= 64) chk({tag, "_access_bound"}, 64'(g), 64'(0));
    PREADY = 1'b0;
    chk({tag, "_pen_cycles"}, 64'(pen_cyc), 64'(v.exp_pen));
    chk({tag, "_rsp"}, {29'h0, rsp_valid, rsp_err, PSELx, rsp_rdata},
        {29'h0, 1'b1, v.exp_err, 1'b0, v.exp_rd});
    chk({tag, "_idle_ready"}, 64'(cmd_ready), 64'(1));
    @(negedge PCLK);
    chk({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  vec_t tbl[6];
  vec_t rv;
  logic        bb_wr[4];
  logic [31:0] drv_prd;
  logic        hs;
  logic        psel_hist[24];
  int          idx, pulses, last_pulse, first_hi, last_hi, lows;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0,  32'h0BAD0BAD, 1'b0, 32'h0,        1};
    tbl[1] = '{1'b0, 32'h24, 32'h0,        3,  32'hA5A50001, 1'b0, 32'hA5A50001, 4};
    tbl[2] = '{1'b0, 32'h30, 32'h0,        16, 32'h11112222, 1'b1, 32'h0,        16};
    tbl[3] = '{1'b1, 32'h34, 32'hCAFEF00D, 15, 32'hFFFFFFFF, 1'b0, 32'h0,        16};
    tbl[4] = '{1'b0, 32'h38, 32'h0,        15, 32'h77778888, 1'b0, 32'h77778888, 16};
    tbl[5] = '{1'b1, 32'h3C, 32'h12345678, 25, 32'h0,        1'b1, 32'h0,        16};

    // Reset held with random inputs
    PRESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    PREADY = 0; PRDATA = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom;
      cmd_wdata = $urandom; PREADY = 1'($urandom); PRDATA = $urandom;
      @(negedge PCLK);
      chk("reset_ctl", {58'h0, cmd_ready, PSELx, PENABLE, PWRITE, rsp_valid, rsp_err}, 64'h0);
      chk("reset_bus", {PADDR, PWDATA}, 64'h0);
      chk("reset_rdata", 64'(rsp_rdata), 64'h0);
    end
    cmd_valid = 1'b0; PREADY = 1'b0; PRESETn = 1'b1;
    #1 chk("release_ready_pre_edge", 64'(cmd_ready), 64'(0));
    @(negedge PCLK);
    chk("release_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 6; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv = ref_model(1'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, TIMEOUT + 3)), $urandom);
      run_xfer(rv, $sformatf("rnd%0d", i));
    end

    // Reset during the second wait state of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("midreset_in_access", {62'h0, PSELx, PENABLE}, 64'b11);
    #2 PRESETn = 1'b0;
    #1 chk("midreset_async_drop", {62'h0, PSELx, PENABLE}, 64'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("midreset_no_rsp", {62'h0, rsp_valid, cmd_ready}, 64'h0);
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("midreset_after_no_rsp", 64'(rsp_valid), 64'(0));
    end
    run_xfer(ref_model(1'b1, 32'h54, 32'h600DF00D, 1, 32'h0), "post_reset");

    // Back-to-back: cmd_valid held, PREADY tied high
    bb_wr = '{1'b1, 1'b0, 1'b1, 1'b0};
    idx = 0; pulses = 0; last_pulse = -1;
    cmd_valid = 1'b1; cmd_write = bb_wr[0]; cmd_addr = 32'h40; cmd_wdata = $urandom;
    PREADY = 1'b1; PRDATA = $urandom;
    for (int c = 0; c < 24; c++) begin
      hs = cmd_valid && cmd_ready;
      drv_prd = PRDATA;
      @(negedge PCLK);
      if (rsp_valid) begin
        if (pulses < 4)
          chk("b2b_rsp", {31'h0, rsp_err, rsp_rdata},
              {31'h0, 1'b0, (bb_wr[pulses] ? 32'h0 : drv_prd)});
        if (last_pulse >= 0) chk("b2b_spacing", 64'(c - last_pulse), 64'(3));
        last_pulse = c; pulses++;
      end
      psel_hist[c] = PSELx;
      PRDATA = $urandom;
      if (hs) begin
        idx++;
        if (idx < 4) begin
          cmd_write = bb_wr[idx]; cmd_addr = 32'h40 + 32'(idx * 4); cmd_wdata = $urandom;
        end else cmd_valid = 1'b0;
      end
    end
    chk("b2b_pulses", 64'(pulses), 64'(4));
    first_hi = -1; last_hi = -1; lows = 0;
    for (int c = 0; c < 24; c++) if (psel_hist[c]) begin
      if (first_hi < 0) first_hi = c;
      last_hi = c;
    end
    for (int c = 0; c < 24; c++)
      if (first_hi >= 0 && c > first_hi && c < last_hi && !psel_hist[c]) lows++;
    chk("b2b_psel_gaps", 64'(lows), 64'(3));
    PREADY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

The APB requester that drives the slave-side bus (PSELx, PENABLE, PADDR, PWRITE, PWDATA) and consumes PREADY/PRDATA. It converts single commands from a local valid/ready command port into compliant APB SETUP/ACCESS sequences. It returns one response per command with read data or a timeout error. It sits between the local control logic and a single APB slave, and replaces the bench-side stimulus as the production bus driver.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 32, width of write/read data paths
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (must be ≥ 2)

Ports:
- PCLK  in  1  bus clock; the single clock, all logic on its rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  local command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transfer aborted by timeout
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  1  slave select
- PENABLE  out  1  ACCESS phase indicator
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  slave ready / end of ACCESS
- PRDATA  in  DATA_WIDTH  slave read data

## Operation
- States: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - cmd_ready = 1, PSELx = 0, PENABLE = 0.
  - A handshake occurs when cmd_valid && cmd_ready at a rising edge. On handshake, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP: PSELx = 1, PENABLE = 0, cmd_ready = 0. Always advances to ACCESS after exactly one cycle.
- ACCESS: PSELx = 1, PENABLE = 1, cmd_ready = 0. PREADY is sampled at each rising edge.
  - PREADY = 1: transfer completes and the state returns to IDLE.
    - For a read, rsp_rdata ← PRDATA.
    - For a write, rsp_rdata ← 0.
    - rsp_err ← 0 and rsp_valid ← 1.
  - PREADY = 0: the wait counter increments.
  - Abort: on the TIMEOUT-th consecutive ACCESS edge with PREADY = 0, the transfer aborts. rsp_valid ← 1, rsp_err ← 1, rsp_rdata ← 0, and the state returns to IDLE.
  - The wait counter clears on entry to ACCESS. Counter width is $clog2(TIMEOUT+1).
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE (no return to 0).
- rsp_valid is high for exactly one cycle per accepted command. It has no backpressure, so the consumer must take it.
- cmd_ready is low from SETUP until the cycle in which rsp_valid is high. Only one command is outstanding at a time.
- Reset:
  - Assertion of PRESETn = 0, at any time including mid-ACCESS, immediately forces state IDLE.
  - All outputs go to their reset values: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata and the wait counter = 0; cmd_ready = 0.
  - No response is issued for an interrupted transfer.
  - cmd_ready rises on the first PCLK edge after PRESETn deasserts.

## Timing
- A handshake at edge N gives SETUP in cycle N→N+1 and ACCESS from edge N+1.
- Zero-wait completion (PREADY = 1 at edge N+2):
  - rsp_valid and cmd_ready are high in cycle N+2→N+3.
  - The next handshake is possible at edge N+3.
- Each wait state adds one cycle. The minimum transfer is 3 cycles from handshake to the next possible handshake.
- Timeout: the abort response appears after edge N+1+TIMEOUT.
- PRDATA is captured only on the completing edge. PRDATA values on non-completing edges are ignored.
- PSELx and PENABLE deassert on the same edge that raises rsp_valid, so there is no idle gap on the response side.

## Test plan
- Reset:
  - Hold PRESETn = 0 with random inputs; all outputs must stay 0, including cmd_ready.
  - Release PRESETn; cmd_ready must be 1 after the first edge.
- Zero-wait write: cmd_write = 1, cmd_addr = 0x10, cmd_wdata = 0xDEADBEEF, PREADY tied 1.
  - One SETUP cycle, then one ACCESS cycle, with PADDR = 0x10 and PWDATA = 0xDEADBEEF.
  - Then rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: read of 0x24; PREADY is low for 3 ACCESS edges and high on the 4th, with PRDATA = 0xA5A5_0001.
  - PENABLE must be high for 4 cycles.
  - rsp_rdata must be 0xA5A5_0001, and PADDR must be stable throughout.
- Timeout: with TIMEOUT = 16 and PREADY held 0, PENABLE must be high for 16 cycles.
  - Then rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and the state returns to IDLE.
- Reset mid-ACCESS: assert PRESETn = 0 during the second wait state.
  - PSELx and PENABLE must drop without waiting for an edge, and no rsp_valid may follow.
  - After release, a new write must complete normally.
- Back-to-back: hold cmd_valid = 1 with 4 alternating write/read commands and PREADY tied 1.
  - Exactly 4 rsp_valid pulses must occur, spaced 3 cycles apart.
  - PSELx must be low for exactly one cycle between transfers.
